// File: rtl/config_chain_loader.sv
// Configuration chain loader: takes WORD_W-bit bitstream words over a
// valid/ready handshake and serialises them LSB-first into a configuration
// flip-flop chain of CHAIN_LEN bits. A starvation watchdog and abort are included.
module config_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 2048,
  parameter int TIMEOUT   = 255
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [15:0] LAST_BIT   = 16'(CHAIN_LEN - 1);
  localparam logic [15:0] STARVE_MAX = 16'(TIMEOUT);
  localparam logic [5:0]  LAST_IDX   = 6'(WORD_W - 1);

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic              buf_full;
  logic [5:0]        bit_idx;
  logic [15:0]       bit_cnt;
  logic [15:0]       starve;
  logic              accept;

  // A new word is taken when the buffer is empty, or on the final bit of the
  // current word provided that bit is not the last one of the chain.
  assign cfg_ready = (state == ST_LOAD) &&
                     (!buf_full || ((bit_idx == LAST_IDX) && (bit_cnt < LAST_BIT)));
  assign accept    = cfg_valid && cfg_ready;

  // All outputs decode registered state only, so no input reaches them combinationally.
  assign ccff_en   = (state == ST_LOAD) && buf_full;
  assign ccff_head = sreg[0];
  assign busy      = (state == ST_LOAD);
  assign done      = (state == ST_DONE);
  assign error     = (state == ST_ERROR);

  // Control FSM and serialising datapath.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state    <= ST_IDLE;
      sreg     <= '0;
      buf_full <= 1'b0;
      bit_idx  <= '0;
      bit_cnt  <= '0;
      starve   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (abort) begin
            state    <= ST_IDLE;
            buf_full <= 1'b0;
          end else if (start) begin
            state    <= ST_LOAD;
            buf_full <= 1'b0;
            bit_idx  <= '0;
            bit_cnt  <= '0;
            starve   <= '0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state    <= ST_IDLE;
            buf_full <= 1'b0;
          end else if (starve == STARVE_MAX) begin
            state    <= ST_ERROR;
            buf_full <= 1'b0;
          end else if (buf_full) begin
            if (bit_cnt == LAST_BIT) begin
              // Final chain bit shifted; leftover bits of this word are dropped.
              state    <= ST_DONE;
              buf_full <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 16'd1;
              if (accept) begin
                // Reload on the word's last bit so the chain shifts without a bubble.
                sreg    <= cfg_data;
                bit_idx <= '0;
                starve  <= '0;
              end else begin
                sreg    <= sreg >> 1;
                bit_idx <= bit_idx + 6'd1;
                if (bit_idx == LAST_IDX) begin
                  buf_full <= 1'b0;
                end
              end
            end
          end else begin
            if (accept) begin
              sreg     <= cfg_data;
              bit_idx  <= '0;
              buf_full <= 1'b1;
              starve   <= '0;
            end else if (!cfg_valid) begin
              starve <= starve + 16'd1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          buf_full <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: three instances (long chain with relaxed
// watchdog, long chain with short watchdog, single-bit chain) checked against a
// bit-queue reference model every cycle, plus directed scenario checks.
module tb_config_chain_loader;

  localparam int NI = 3;
  localparam int CL [NI] = '{40, 40, 1};
  localparam int TO [NI] = '{16, 4, 4};

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] st, ab, vl;
  logic [31:0]   dt [NI];
  logic [NI-1:0] rdy, hd, en, bs, dn, er;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  config_chain_loader #(.WORD_W(32), .CHAIN_LEN(40), .TIMEOUT(16)) u_a (
    .prog_clk(clk), .pReset(rst), .start(st[0]), .abort(ab[0]),
    .cfg_data(dt[0]), .cfg_valid(vl[0]), .cfg_ready(rdy[0]),
    .ccff_head(hd[0]), .ccff_en(en[0]), .busy(bs[0]), .done(dn[0]), .error(er[0]));

  config_chain_loader #(.WORD_W(32), .CHAIN_LEN(40), .TIMEOUT(4)) u_b (
    .prog_clk(clk), .pReset(rst), .start(st[1]), .abort(ab[1]),
    .cfg_data(dt[1]), .cfg_valid(vl[1]), .cfg_ready(rdy[1]),
    .ccff_head(hd[1]), .ccff_en(en[1]), .busy(bs[1]), .done(dn[1]), .error(er[1]));

  config_chain_loader #(.WORD_W(32), .CHAIN_LEN(1), .TIMEOUT(4)) u_c (
    .prog_clk(clk), .pReset(rst), .start(st[2]), .abort(ab[2]),
    .cfg_data(dt[2]), .cfg_valid(vl[2]), .cfg_ready(rdy[2]),
    .ccff_head(hd[2]), .ccff_en(en[2]), .busy(bs[2]), .done(dn[2]), .error(er[2]));

  // Reference model: mode 0 idle, 1 loading, 2 finished, 3 timed out.
  // mpos is the index of the next unsent bit of mword; 32 means nothing buffered.
  int          mode   [NI];
  int          mpos   [NI];
  int          shifts [NI];
  int          starve [NI];
  logic [31:0] mword  [NI];
  logic        mvalid [NI];

  function automatic logic exp_rdy(input int i);
    return (mode[i] == 1) &&
           ((mpos[i] == 32) || ((mpos[i] == 31) && (shifts[i] < CL[i] - 1)));
  endfunction

  task automatic model_step(input int i);
    logic acc;
    if (rst) begin
      mode[i] = 0; mpos[i] = 32; shifts[i] = 0; starve[i] = 0; mvalid[i] = 1'b1;
    end else if (mode[i] != 1) begin
      if (ab[i]) begin
        mode[i] = 0; mpos[i] = 32;
      end else if (st[i]) begin
        mode[i] = 1; mpos[i] = 32; shifts[i] = 0; starve[i] = 0;
      end
    end else if (ab[i]) begin
      mode[i] = 0; mpos[i] = 32;
    end else if (starve[i] == TO[i]) begin
      mode[i] = 3; mpos[i] = 32;
    end else begin
      acc = vl[i] && exp_rdy(i);
      if (mpos[i] < 32) begin
        shifts[i]++;
        if (shifts[i] == CL[i]) begin
          mode[i] = 2; mpos[i] = 32;
        end else if (acc) begin
          mword[i] = dt[i]; mpos[i] = 0; starve[i] = 0;
        end else begin
          mpos[i]++;
        end
      end else if (acc) begin
        mword[i] = dt[i]; mpos[i] = 0; starve[i] = 0;
      end else begin
        starve[i]++;
      end
    end
  endtask

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", name, i, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) mvalid[i] = 1'b0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) model_step(i);
    end
  end

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (mvalid[i]) begin
          logic e_en;
          e_en = (mode[i] == 1) && (mpos[i] < 32);
          chk("cfg_ready", i, 64'(rdy[i]), 64'(exp_rdy(i)));
          chk("ccff_en",   i, 64'(en[i]),  64'(e_en));
          if (e_en) chk("ccff_head", i, 64'(hd[i]), 64'(mword[i][mpos[i]]));
          chk("busy",  i, 64'(bs[i]), 64'(mode[i] == 1));
          chk("done",  i, 64'(dn[i]), 64'(mode[i] == 2));
          chk("error", i, 64'(er[i]), 64'(mode[i] == 3));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic all_zero(input string name);
    for (int i = 0; i < NI; i++)
      chk(name, i, 64'({rdy[i], hd[i], en[i], bs[i], dn[i], er[i]}), 64'd0);
  endtask

  // Start a load, feed w1 then w2; after w1 has fully drained, hold valid low
  // for 'gap' empty-buffer cycles. Records shifted bits and timing.
  task automatic stream(input int i, input logic [31:0] w1, input logic [31:0] w2, input int gap,
                        output int n_en, output int first, output int last,
                        output int done_at, output logic [63:0] bits);
    int  sent, gcnt;
    logic acc;
    n_en = 0; first = -1; last = -1; done_at = -1; bits = '0; sent = 0; gcnt = 0;
    st[i] = 1'b1;
    cyc();
    st[i] = 1'b0;
    dt[i] = w1;
    vl[i] = 1'b1;
    for (int c = 0; c < 120; c++) begin
      acc = rdy[i] && vl[i];
      cyc();
      if (acc) begin
        sent++;
        if (sent == 1) begin
          dt[i] = w2;
          vl[i] = (gap == 0);
        end else begin
          vl[i] = 1'b0;
          chk("ready_low_after_w2", i, 64'(rdy[i]), 64'd0);
        end
      end
      if (en[i]) begin
        bits[n_en] = hd[i];
        n_en++;
        if (first < 0) first = c;
        last = c;
      end else if (bs[i] && sent == 1 && gap > 0 && !vl[i]) begin
        gcnt++;
        if (gcnt == gap) vl[i] = 1'b1;
      end
      if (dn[i]) begin
        done_at = c;
        break;
      end
    end
    vl[i] = 1'b0;
  endtask

  initial begin
    int n, f, l, d, k;
    logic [63:0] b;
    logic saw_en;
    rst = 1'b1; st = '0; ab = '0; vl = '0;
    for (int i = 0; i < NI; i++) dt[i] = '0;

    cyc();
    all_zero("in_reset");
    cyc();
    rst = 1'b0;
    cyc();
    all_zero("after_reset");

    // Back-to-back words into a 40-bit chain.
    stream(0, 32'hA5A5A5A5, 32'h000000FF, 0, n, f, l, d, b);
    chk("stream_shift_count", 0, 64'(n), 64'd40);
    chk("stream_no_bubble",   0, 64'(l - f + 1), 64'd40);
    chk("stream_done_timing", 0, 64'(d), 64'(l + 1));
    chk("stream_bits",        0, b, 64'h00000000FF_A5A5A5A5);

    // abort together with start while done.
    chk("done_held", 0, 64'(dn[0]), 64'd1);
    st[0] = 1'b1; ab[0] = 1'b1;
    cyc();
    st[0] = 1'b0; ab[0] = 1'b0;
    chk("abort_start_busy", 0, 64'(bs[0]), 64'd0);
    chk("abort_start_done", 0, 64'(dn[0]), 64'd0);

    // Five-cycle stall between words.
    stream(0, 32'h12345678, 32'h9ABCDEF0, 5, n, f, l, d, b);
    chk("stall_shift_count", 0, 64'(n), 64'd40);
    chk("stall_gap",         0, 64'(l - f + 1 - n), 64'd5);
    chk("stall_done_timing", 0, 64'(d), 64'(l + 1));
    chk("stall_bits",        0, b, 64'h00000000F0_12345678);

    // Starvation watchdog with TIMEOUT=4.
    st[1] = 1'b1; vl[1] = 1'b0;
    cyc();
    st[1] = 1'b0;
    k = 0; saw_en = 1'b0;
    while (!er[1] && k < 20) begin
      if (en[1]) saw_en = 1'b1;
      cyc();
      k++;
    end
    chk("timeout_cycle", 1, 64'(k), 64'd5);
    chk("timeout_no_en", 1, 64'(saw_en), 64'd0);
    st[1] = 1'b1;
    cyc();
    chk("restart_busy",  1, 64'(bs[1]), 64'd1);
    chk("restart_error", 1, 64'(er[1]), 64'd0);
    cyc();
    st[1] = 1'b0;
    k = 1;
    while (!er[1] && k < 20) begin
      cyc();
      k++;
    end
    chk("start_ignored_in_load", 1, 64'(k), 64'd5);
    ab[1] = 1'b1;
    cyc();
    ab[1] = 1'b0;
    chk("abort_error", 1, 64'(er[1]), 64'd0);
    st[1] = 1'b1;
    cyc();
    st[1] = 1'b0;
    cyc();
    ab[1] = 1'b1;
    cyc();
    ab[1] = 1'b0;
    chk("abort_load", 1, 64'(bs[1]), 64'd0);

    // Reset pulse after 10 shifts, then a full reload.
    st[0] = 1'b1;
    cyc();
    st[0] = 1'b0; dt[0] = 32'hC3C3C3C3; vl[0] = 1'b1;
    n = 0; k = 0;
    while (n < 10 && k < 40) begin
      cyc();
      if (en[0]) n++;
      k++;
    end
    chk("pre_reset_shifts", 0, 64'(n), 64'd10);
    rst = 1'b1;
    cyc();
    rst = 1'b0; vl[0] = 1'b0;
    all_zero("midload_reset");
    cyc();
    all_zero("midload_reset_next");
    stream(0, 32'h3C3C3C3C, 32'h0000005A, 0, n, f, l, d, b);
    chk("reload_shift_count", 0, 64'(n), 64'd40);
    chk("reload_bits",        0, b, 64'h000000005A_3C3C3C3C);

    // Single-bit chain.
    stream(2, 32'h00000001, 32'hFFFFFFFE, 0, n, f, l, d, b);
    chk("len1_shift_count", 2, 64'(n), 64'd1);
    chk("len1_bit",         2, b, 64'd1);
    chk("len1_done_timing", 2, 64'(d), 64'(l + 1));

    repeat (3) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
